// File: rtl/sha256_compress.sv
// sha256_compress
//   SHA-256 compression stage. Accepts the 64 schedule words of one 512-bit
//   block, one per handshake. It runs the 64 rounds against an internal K
//   ROM. It then folds the working variables a..h into the chaining value
//   H0..H7, and that chaining value is presented as the digest.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start_in         begin a block (sampled only in IDLE)
//   first_block_in   with start_in: 1 = seed from the IV, 0 = chain from H
//   w_valid_in       w_in carries a valid schedule word
//   w_in             schedule word W[t], t = 0..63 in order
//   w_ready_out      high in ROUND; word accepted on w_valid_in && w_ready_out
//   busy_out         high whenever the block is not idle
//   digest_out       {H0..H7}, H0 in [255:224]
//   digest_valid_out one-cycle pulse when the digest has just been updated
//   o_FSM_state      current state (IDLE=0, ROUND=1, FINAL=2, DONE=3)
//   o_round          index t of the next word to be accepted
//
// Only DATA_WIDTH = 32 is meaningful; the round functions are 32-bit.
module sha256_compress #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic                  first_block_in,
  input  logic                  w_valid_in,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic                  w_ready_out,
  output logic                  busy_out,
  output logic [255:0]          digest_out,
  output logic                  digest_valid_out,
  output logic [1:0]            o_FSM_state,
  output logic [5:0]            o_round
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ROUND = 2'b01,
    S_FINAL = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [5:0] LAST_ROUND = 6'd63;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Round functions; rotations are written as fixed concatenations.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] choose(input logic [31:0] e, input logic [31:0] f,
                                         input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] majority(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_t;
  logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [31:0] r_hash [8];
  logic        w_accept;
  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_accept = w_valid_in && (r_state == S_ROUND);
  assign w_t1     = r_h + big_sigma1(r_e) + choose(r_e, r_f, r_g) + K_ROM[r_t] + w_in;
  assign w_t2     = big_sigma0(r_a) + majority(r_a, r_b, r_c);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_next_state = S_ROUND;
      S_ROUND: if (w_accept && (r_t == LAST_ROUND)) w_next_state = S_FINAL;
      S_FINAL: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_ready_out      = (r_state == S_ROUND);
    busy_out         = (r_state != S_IDLE);
    digest_valid_out = (r_state == S_DONE);
  end

  assign o_FSM_state = r_state;
  assign o_round     = r_t;
  assign digest_out  = {r_hash[0], r_hash[1], r_hash[2], r_hash[3],
                        r_hash[4], r_hash[5], r_hash[6], r_hash[7]};

  // Working variables, round counter and chaining value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t <= '0;
      r_a <= '0; r_b <= '0; r_c <= '0; r_d <= '0;
      r_e <= '0; r_f <= '0; r_g <= '0; r_h <= '0;
      for (int i = 0; i < 8; i++) r_hash[i] <= IV[i];
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_t <= '0;
            if (first_block_in) begin
              for (int i = 0; i < 8; i++) r_hash[i] <= IV[i];
              r_a <= IV[0]; r_b <= IV[1]; r_c <= IV[2]; r_d <= IV[3];
              r_e <= IV[4]; r_f <= IV[5]; r_g <= IV[6]; r_h <= IV[7];
            end else begin
              r_a <= r_hash[0]; r_b <= r_hash[1]; r_c <= r_hash[2]; r_d <= r_hash[3];
              r_e <= r_hash[4]; r_f <= r_hash[5]; r_g <= r_hash[6]; r_h <= r_hash[7];
            end
          end
        end
        S_ROUND: begin
          // Stalls simply hold everything; the counter wraps 63 -> 0 by width.
          if (w_valid_in) begin
            r_h <= r_g;
            r_g <= r_f;
            r_f <= r_e;
            r_e <= r_d + w_t1;
            r_d <= r_c;
            r_c <= r_b;
            r_b <= r_a;
            r_a <= w_t1 + w_t2;
            r_t <= r_t + 6'd1;
          end
        end
        S_FINAL: begin
          r_hash[0] <= r_hash[0] + r_a;
          r_hash[1] <= r_hash[1] + r_b;
          r_hash[2] <= r_hash[2] + r_c;
          r_hash[3] <= r_hash[3] + r_d;
          r_hash[4] <= r_hash[4] + r_e;
          r_hash[5] <= r_hash[5] + r_f;
          r_hash[6] <= r_hash[6] + r_g;
          r_hash[7] <= r_hash[7] + r_h;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress. A textbook SHA-256 block model
// (schedule expansion plus 64 rounds on plain arrays) supplies the schedule
// words driven into the DUT and the expected chained digests.
module tb_sha256_compress;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_in = 1'b0;
  logic         first_block_in = 1'b0;
  logic         w_valid_in = 1'b0;
  logic [31:0]  w_in = '0;
  logic         w_ready_out;
  logic         busy_out;
  logic [255:0] digest_out;
  logic         digest_valid_out;
  logic [1:0]   o_FSM_state;
  logic [5:0]   o_round;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_count = 0;

  sha256_compress #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_in         (start_in),
    .first_block_in   (first_block_in),
    .w_valid_in       (w_valid_in),
    .w_in             (w_in),
    .w_ready_out      (w_ready_out),
    .busy_out         (busy_out),
    .digest_out       (digest_out),
    .digest_valid_out (digest_valid_out),
    .o_FSM_state      (o_FSM_state),
    .o_round          (o_round)
  );

  always #5 clk = ~clk;

  // Count digest_valid pulses shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (digest_valid_out === 1'b1) dv_count++;
  end

  localparam logic [255:0] IV_D =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_D =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_D =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [511:0] abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
  logic [511:0] two_blk1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  logic [511:0] two_blk2 = {480'h0, 32'h000001c0};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full 64-word schedule, W[t] at bits [32t +: 32].
  function automatic logic [2047:0] expand(input logic [511:0] blk);
    logic [31:0]   w [64];
    logic [2047:0] r;
    logic [31:0]   s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int t = 0; t < 64; t++) r[32*t +: 32] = w[t];
    return r;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]   h [8];
    logic [31:0]   v [8];
    logic [2047:0] sch;
    logic [31:0]   t1, t2, wt;
    logic [255:0]  r;
    sch = expand(blk);
    for (int i = 0; i < 8; i++) begin
      h[i] = hin[255 - 32*i -: 32];
      v[i] = h[i];
    end
    for (int t = 0; t < 64; t++) begin
      wt = sch[32*t +: 32];
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wt;
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[i] + v[i];
    return r;
  endfunction

  // Wait for IDLE, then pulse start_in; returns just after the start edge.
  task automatic start_block(input bit first);
    int guard = 0;
    while (o_FSM_state !== 2'b00 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    start_in = 1'b1;
    first_block_in = first;
    @(negedge clk);
    start_in = 1'b0;
    first_block_in = 1'b0;
    n_checks++;
    if (o_FSM_state !== 2'b01 || busy_out !== 1'b1 || w_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL start_enter_round: state=%b busy=%b ready=%b required state=01 busy=1 ready=1",
               o_FSM_state, busy_out, w_ready_out);
    end
  endtask

  // Drive the schedule; mode 0 = continuous, 1 = toggled valid, 2 = random stalls.
  // junk pulses start_in mid-ROUND and offers words during FINAL/DONE.
  // Returns at the DONE cycle (or after a bounded timeout).
  task automatic feed_block(input logic [2047:0] sch, input int mode, input bit junk,
                            output int lat, output int stalls);
    int idx = 0;
    bit v   = 1'b0;
    lat = 0;
    stalls = 0;
    while (digest_valid_out !== 1'b1 && lat < 400) begin
      if (idx < 64) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (lat % 2) == 1;
          default: v = ($urandom_range(3) != 0);
        endcase
        w_valid_in = v;
        w_in       = v ? sch[32*idx +: 32] : $urandom();
        start_in   = junk && (idx == 10);
      end else begin
        start_in   = 1'b0;
        w_valid_in = junk;
        w_in       = $urandom();
      end
      @(negedge clk);
      lat++;
      if (idx < 64) begin
        if (v) idx++;
        else   stalls++;
        if (idx < 64) begin
          n_checks++;
          if (o_round !== 6'(idx) || o_FSM_state !== 2'b01) begin
            n_fail++;
            $display("FAIL round_index: o_round=%0d state=%b required o_round=%0d state=01",
                     o_round, o_FSM_state, idx);
          end
        end
      end
    end
    start_in   = 1'b0;
    w_valid_in = 1'b0;
    if (digest_valid_out !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL feed_timeout: no digest_valid_out within %0d cycles", lat);
    end
  endtask

  task automatic check_digest(input string name, input logic [255:0] exp,
                              input int lat, input int stalls);
    n_checks++;
    if (digest_out !== exp) begin
      n_fail++;
      $display("FAIL %s_digest: got %h required %h", name, digest_out, exp);
    end
    n_checks++;
    if (lat !== 65 + stalls) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, 65 + stalls);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_FSM_state !== 2'b00 || o_round !== 6'd0 || busy_out !== 1'b0 ||
        w_ready_out !== 1'b0 || digest_valid_out !== 1'b0 || digest_out !== IV_D) begin
      n_fail++;
      $display("FAIL reset_values: state=%b round=%0d busy=%b ready=%b dv=%b digest=%h required IV idle",
               o_FSM_state, o_round, busy_out, w_ready_out, digest_valid_out, digest_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abc;
    int lat, st;
    start_block(1'b1);
    feed_block(expand(abc_blk), 0, 1'b0, lat, st);
    check_digest("abc", ABC_D, lat, st);
  endtask

  task automatic test_stall;
    int lat, st;
    start_block(1'b1);
    feed_block(expand(abc_blk), 1, 1'b0, lat, st);
    check_digest("abc_stall", ABC_D, lat, st);
  endtask

  // Two-block message with the second start sampled at the earliest legal edge.
  task automatic test_back_to_back;
    int lat, st;
    start_block(1'b1);
    feed_block(expand(two_blk1), 0, 1'b0, lat, st);
    check_digest("two_blk1", compress(IV_D, two_blk1), lat, st);
    start_in = 1'b1;
    first_block_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_FSM_state !== 2'b00) begin
      n_fail++;
      $display("FAIL start_in_done_ignored: state=%b required 00", o_FSM_state);
    end
    @(negedge clk);
    start_in = 1'b0;
    n_checks++;
    if (o_FSM_state !== 2'b01 || o_round !== 6'd0) begin
      n_fail++;
      $display("FAIL b2b_start: state=%b round=%0d required 01 round 0", o_FSM_state, o_round);
    end
    feed_block(expand(two_blk2), 0, 1'b0, lat, st);
    check_digest("two_msg", TWO_D, lat, st);
  endtask

  task automatic test_ignored_inputs;
    int lat, st;
    start_block(1'b1);
    feed_block(expand(abc_blk), 0, 1'b1, lat, st);
    check_digest("abc_junk", ABC_D, lat, st);
    w_valid_in = 1'b1;
    w_in = $urandom();
    repeat (2) @(negedge clk);
    w_valid_in = 1'b0;
    n_checks++;
    if (o_FSM_state !== 2'b00 || o_round !== 6'd0 || digest_out !== ABC_D) begin
      n_fail++;
      $display("FAIL idle_hold: state=%b round=%0d digest=%h required 00 0 %h",
               o_FSM_state, o_round, digest_out, ABC_D);
    end
  endtask

  task automatic test_mid_reset;
    int lat, st, dv_before;
    logic [2047:0] sch;
    sch = expand(abc_blk);
    start_block(1'b1);
    for (int i = 0; i < 30; i++) begin
      w_valid_in = 1'b1;
      w_in = sch[32*i +: 32];
      @(negedge clk);
    end
    w_valid_in = 1'b0;
    n_checks++;
    if (o_round !== 6'd30) begin
      n_fail++;
      $display("FAIL pre_reset_round: got %0d required 30", o_round);
    end
    dv_before = dv_count;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_FSM_state !== 2'b00 || digest_out !== IV_D || o_round !== 6'd0 ||
        busy_out !== 1'b0 || w_ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_values: state=%b round=%0d digest=%h required 00 0 IV",
               o_FSM_state, o_round, digest_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_block(1'b1);
    feed_block(sch, 0, 1'b0, lat, st);
    check_digest("abc_after_reset", ABC_D, lat, st);
    n_checks++;
    if (dv_count - dv_before !== 1) begin
      n_fail++;
      $display("FAIL reset_pulse_count: got %0d required 1", dv_count - dv_before);
    end
  endtask

  task automatic test_chain_stale;
    int lat, st;
    start_block(1'b1);
    feed_block(expand(abc_blk), 0, 1'b0, lat, st);
    start_block(1'b0);
    feed_block(expand(abc_blk), 0, 1'b0, lat, st);
    check_digest("abc_chain", compress(ABC_D, abc_blk), lat, st);
  endtask

  task automatic test_random;
    int lat, st;
    logic [511:0] blk;
    logic [255:0] h;
    h = IV_D;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom();
      h = compress(h, blk);
      start_block(b == 0);
      feed_block(expand(blk), 2, (b == 2), lat, st);
      check_digest("random_chain", h, lat, st);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_stall();
    test_back_to_back();
    test_ignored_inputs();
    test_mid_reset();
    test_chain_stale();
    test_random();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
